// File: rtl/fifo_drain.sv
// Read-side controller: pops a 4-entry byte FIFO and streams bytes out on a valid/ready port.
// Latency: a byte is presented on m_data two cycles after its accepted fifo_rd_en (1 FIFO + 1 capture).
// Backpressure: a 2-entry buffer absorbs in-flight bytes; pops are throttled so nothing is lost or duplicated.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   enable            1 = fetch from the FIFO, 0 = finish outstanding bytes and go idle
//   fifo_empty/full   FIFO status flags
//   fifo_wr_en        FIFO write request; a write wins over a read in the same cycle
//   fifo_out          FIFO registered read data (valid one cycle after an accepted pop)
//   fifo_rd_en        pop request to the FIFO
//   m_valid/m_ready/m_data  output byte stream
//   busy              not IDLE, a fetch in flight, or buffered bytes pending
//   byte_count        delivered-byte counter, wraps modulo 2^COUNT_W
//
// Optional build macro FIFO_DRAIN_PARITY_EN adds input parity_odd and output m_parity
// (even parity of m_data, inverted when parity_odd=1, 0 when no byte is presented).

module fifo_drain #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic               fifo_wr_en,
  input  logic [7:0]         fifo_out,
  output logic               fifo_rd_en,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
`ifdef FIFO_DRAIN_PARITY_EN
  input  logic               parity_odd,
  output logic               m_parity,
`endif
  output logic               busy,
  output logic [COUNT_W-1:0] byte_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [7:0]  buf_dat [2];
  logic        buf_head;
  logic        buf_tail;
  logic [1:0]  buf_cnt;
  logic        inflight;

  logic        pop;
  logic        push;
  logic        accepted;
  logic [2:0]  occupancy;

`ifdef FIFO_DRAIN_PARITY_EN
  logic [1:0]  buf_par;
`endif

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf_dat[buf_head];
  assign pop     = m_valid && m_ready;
  // The byte popped last cycle is sitting on fifo_out now.
  assign push    = inflight;

  // Slots that will be committed after this edge: buffered + in flight - leaving.
  // pop implies buf_cnt >= 1, so this never underflows.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  // The FIFO services a write instead of a read when both arrive and it has room,
  // so such a request is dropped here and naturally retried next cycle.
  assign accepted = fifo_rd_en && !fifo_empty && !(fifo_wr_en && !fifo_full);

  assign busy = (state_q != IDLE) || inflight || (buf_cnt != 2'd0);

`ifdef FIFO_DRAIN_PARITY_EN
  assign m_parity = m_valid && (buf_par[buf_head] ^ parity_odd);
`endif

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        fifo_rd_en = !fifo_empty && (occupancy < 3'd2);
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (!inflight && (buf_cnt == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      inflight   <= 1'b0;
      buf_dat[0] <= 8'h00;
      buf_dat[1] <= 8'h00;
      buf_head   <= 1'b0;
      buf_tail   <= 1'b0;
      buf_cnt    <= 2'd0;
      byte_count <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
      buf_par    <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      inflight <= accepted;

      if (push) begin
        buf_dat[buf_tail] <= fifo_out;
`ifdef FIFO_DRAIN_PARITY_EN
        buf_par[buf_tail] <= ^fifo_out;
`endif
        buf_tail <= ~buf_tail;
      end

      if (pop) begin
        buf_head   <= ~buf_head;
        byte_count <= byte_count + 1'b1;
      end

      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

endmodule
